// File: rtl/pool_relu.sv
// 2x2 stride-2 max pooling fused with ReLU over a conv output map held in DRAM.
// Reads four neighbours per output pixel, writes max(0, a, b, c, d) back to DRAM.
module pool_relu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [5:0]            num_chnls,
  input  logic [5:0]            ofmap_width,
  input  logic [5:0]            ofmap_height,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  dram_en_wr,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  done
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    RD   = 4'b0010,
    WR   = 4'b0100,
    DONE = 4'b1000
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RD_BASE = ADDR_WIDTH'(18'd131072);
  localparam logic [ADDR_WIDTH-1:0] WR_BASE = ADDR_WIDTH'(18'd196608);

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  state_t                state, state_nxt;
  logic [1:0]            cnt;
  logic [4:0]            px, py;
  logic [5:0]            chnl;
  logic [5:0]            chnls_smp;
  logic [4:0]            w_half, h_half;
  logic [DATA_WIDTH-1:0] max_val;

  logic                  start_ok;
  logic [4:0]            px_max, py_max;
  logic [5:0]            chnl_max;
  logic                  px_last, py_last, chnl_last, pix_last;
  logic [4:0]            x, y;
  logic [17:0]           rd_ofs, wr_ofs;

  assign start_ok  = (num_chnls != 6'd0) && (ofmap_width >= 6'd2) && (ofmap_height >= 6'd2);
  assign px_max    = w_half - 5'd1;
  assign py_max    = h_half - 5'd1;
  assign chnl_max  = chnls_smp - 6'd1;
  assign px_last   = (px == px_max);
  assign py_last   = (py == py_max);
  assign chnl_last = (chnl == chnl_max);
  assign pix_last  = px_last && py_last && chnl_last;

  // cnt[0] selects the right column, cnt[1] the lower row of the 2x2 window
  assign x      = {px[3:0], cnt[0]};
  assign y      = {py[3:0], cnt[1]};
  assign rd_ofs = {4'd0, chnl[3:0], y, x};
  assign wr_ofs = {4'd0, chnl[3:0], py, px};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = start_ok ? RD : DONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD: begin
        if (cnt == 2'd3) begin
          state_nxt = WR;
        end else begin
          state_nxt = RD;
        end
      end
      WR: begin
        if (pix_last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Parameters are captured only on the start cycle so later input changes cannot disturb a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 2'd0;
      px        <= 5'd0;
      py        <= 5'd0;
      chnl      <= 6'd0;
      chnls_smp <= 6'd0;
      w_half    <= 5'd0;
      h_half    <= 5'd0;
      max_val   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 2'd0;
          if (enable) begin
            chnls_smp <= num_chnls;
            w_half    <= ofmap_width[5:1];
            h_half    <= ofmap_height[5:1];
            px        <= 5'd0;
            py        <= 5'd0;
            chnl      <= 6'd0;
            max_val   <= '0;
          end
        end
        RD: begin
          cnt <= cnt + 2'd1;
          // data_in lags the address by one cycle, so cnt 0 only seeds the ReLU floor
          if (cnt == 2'd0) begin
            max_val <= '0;
          end else begin
            max_val <= smax(max_val, data_in);
          end
        end
        WR: begin
          cnt <= 2'd0;
          if (px_last) begin
            px <= 5'd0;
            if (py_last) begin
              py   <= 5'd0;
              chnl <= chnl_last ? 6'd0 : chnl + 6'd1;
            end else begin
              py <= py + 5'd1;
            end
          end else begin
            px <= px + 5'd1;
          end
        end
        DONE: begin
          cnt <= 2'd0;
        end
        default: begin
          cnt <= 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    dram_en_rd = 1'b0;
    addr_in    = '0;
    dram_en_wr = 1'b0;
    addr_out   = '0;
    data_out   = '0;
    done       = 1'b0;
    case (state)
      RD: begin
        dram_en_rd = 1'b1;
        addr_in    = RD_BASE + ADDR_WIDTH'(rd_ofs);
      end
      WR: begin
        dram_en_wr = 1'b1;
        addr_out   = WR_BASE + ADDR_WIDTH'(wr_ofs);
        data_out   = smax(max_val, data_in);
      end
      DONE:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pool_relu.sv
// Randomized scoreboard bench for pool_relu: a DRAM model feeds reads, a reference
// model pushes expected reads/writes/done timing, and a negedge monitor compares.
module tb_pool_relu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [5:0]  num_chnls = 6'd0;
  logic [5:0]  ofmap_width = 6'd0;
  logic [5:0]  ofmap_height = 6'd0;
  logic [31:0] data_in;
  logic        dram_en_rd, dram_en_wr, done;
  logic [17:0] addr_in, addr_out;
  logic [31:0] data_out;

  pool_relu dut (
    .clk(clk), .rst(rst), .enable(enable), .num_chnls(num_chnls),
    .ofmap_width(ofmap_width), .ofmap_height(ofmap_height), .data_in(data_in),
    .dram_en_rd(dram_en_rd), .addr_in(addr_in), .dram_en_wr(dram_en_wr),
    .addr_out(addr_out), .data_out(data_out), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DRAM read model: one-cycle latency, garbage when not reading
  logic [31:0] mem [0:4095];
  always @(posedge clk) data_in <= dram_en_rd ? mem[addr_in[11:0]] : $urandom;

  int total = 0;
  int bad   = 0;

  int          rd_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_q[$];
  int          log_addr[$];
  logic [31:0] log_data[$];

  function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      chk({dram_en_rd, dram_en_wr, done} == 3'b000 && addr_in == 18'd0 && addr_out == 18'd0
          && data_out == 32'd0, "reset_outputs",
          longint'({dram_en_rd, dram_en_wr, done}), 0);
    end else begin
      if (dram_en_rd || dram_en_wr)
        chk(!(dram_en_rd && dram_en_wr), "rd_wr_exclusive", longint'({dram_en_rd, dram_en_wr}), 0);
      if (dram_en_rd) begin
        chk(rd_q.size() != 0, "unexpected_read", longint'(addr_in), 0);
        if (rd_q.size() != 0) begin
          int e;
          e = rd_q.pop_front();
          chk(addr_in == 18'(e), "read_addr", longint'(addr_in), longint'(e));
        end
      end else begin
        chk(addr_in == 18'd0, "addr_in_idle", longint'(addr_in), 0);
      end
      if (dram_en_wr) begin
        log_addr.push_back(int'(addr_out));
        log_data.push_back(data_out);
        chk(wr_addr_q.size() != 0, "unexpected_write", longint'(addr_out), 0);
        if (wr_addr_q.size() != 0) begin
          int ea;
          logic [31:0] ed;
          ea = wr_addr_q.pop_front();
          ed = wr_data_q.pop_front();
          chk(addr_out == 18'(ea), "write_addr", longint'(addr_out), longint'(ea));
          chk(data_out == ed, "write_data", longint'(data_out), longint'(ed));
        end
      end else begin
        chk(addr_out == 18'd0 && data_out == 32'd0, "write_bus_idle",
            longint'({addr_out, data_out}), 0);
      end
      if (done) begin
        chk(done_q.size() != 0, "unexpected_done", longint'(cyc), 0);
        if (done_q.size() != 0) begin
          int ec;
          ec = done_q.pop_front();
          chk(cyc == ec, "done_cycle", longint'(cyc), longint'(ec));
        end
      end
    end
  end

  // Reference model: max(0, window) over floor(W/2) x floor(H/2) outputs per channel
  task automatic model(input int c, input int w, input int h, input int en_cyc);
    int n;
    n = 0;
    if (c >= 1 && w >= 2 && h >= 2) begin
      for (int ch = 0; ch < c; ch++)
        for (int py = 0; py < h / 2; py++)
          for (int px = 0; px < w / 2; px++) begin
            int m;
            m = 0;
            for (int k = 0; k < 4; k++) begin
              int x, y, a, v;
              x = 2 * px + (k % 2);
              y = 2 * py + (k / 2);
              a = ch * 1024 + y * 32 + x;
              rd_q.push_back(131072 + a);
              v = int'(mem[a]);
              if (v > m) m = v;
            end
            wr_addr_q.push_back(196608 + ch * 1024 + py * 32 + px);
            wr_data_q.push_back(32'(m));
            n++;
          end
    end
    done_q.push_back(en_cyc + 1 + 5 * n);
  endtask

  task automatic start_run(input int c, input int w, input int h);
    @(posedge clk); #1;
    num_chnls    = 6'(c);
    ofmap_width  = 6'(w);
    ofmap_height = 6'(h);
    enable       = 1'b1;
    model(c, w, h, cyc);
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_q.size() == 0) break;
    end
    chk(done_q.size() == 0, "done_timeout", longint'(done_q.size()), 0);
    chk(rd_q.size() == 0 && wr_addr_q.size() == 0, "pending_transfers",
        longint'(rd_q.size() + wr_addr_q.size()), 0);
    done_q.delete(); rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      mem[i] = 32'h8000_0000;
      else if (r == 1) mem[i] = 32'hFFFF_0000;
      else             mem[i] = $urandom;
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) mem[y * 32 + x] = 32'((y * 4 + x) << 16);
  endtask

  task automatic check_ramp_writes();
    int          ea[4];
    logic [31:0] ed[4];
    ea = '{196608, 196609, 196640, 196641};
    ed = '{32'h5_0000, 32'h7_0000, 32'hD_0000, 32'hF_0000};
    chk(log_addr.size() == 4, "ramp_write_count", longint'(log_addr.size()), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      chk(log_addr[i] == ea[i], "ramp_addr", longint'(log_addr[i]), longint'(ea[i]));
      chk(log_data[i] == ed[i], "ramp_data", longint'(log_data[i]), longint'(ed[i]));
    end
  endtask

  initial begin
    fill_random();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ramp map, 4x4 single channel
    fill_ramp();
    log_addr.delete(); log_data.delete();
    start_run(1, 4, 4);
    wait_idle(200);
    check_ramp_writes();

    // all-negative 2x2 window clamps to zero
    mem[0] = 32'hFFFF_0000; mem[1] = 32'h8000_0000;
    mem[32] = 32'h8000_0000; mem[33] = 32'hFFFF_0000;
    log_addr.delete(); log_data.delete();
    start_run(1, 2, 2);
    wait_idle(100);
    chk(log_addr.size() == 1, "neg_write_count", longint'(log_addr.size()), 1);
    if (log_addr.size() == 1) begin
      chk(log_addr[0] == 196608, "neg_addr", longint'(log_addr[0]), 196608);
      chk(log_data[0] == 32'd0, "neg_data", longint'(log_data[0]), 0);
    end

    // odd 5x5 map, two channels
    fill_random();
    log_addr.delete(); log_data.delete();
    start_run(2, 5, 5);
    wait_idle(200);
    chk(log_addr.size() == 8, "odd_write_count", longint'(log_addr.size()), 8);
    if (log_addr.size() == 8) begin
      int ch1[4];
      ch1 = '{197632, 197633, 197664, 197665};
      for (int i = 0; i < 4; i++)
        chk(log_addr[4 + i] == ch1[i], "odd_ch1_addr", longint'(log_addr[4 + i]), longint'(ch1[i]));
    end

    // degenerate parameter sets finish immediately
    start_run(0, 4, 4);
    wait_idle(20);
    start_run(1, 1, 4);
    wait_idle(20);

    // enable and parameter churn during a run
    fill_random();
    start_run(2, 4, 4);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      enable       = 1'($urandom_range(0, 1));
      num_chnls    = 6'($urandom_range(0, 63));
      ofmap_width  = 6'($urandom_range(0, 63));
      ofmap_height = 6'($urandom_range(0, 63));
    end
    enable = 1'b0;
    wait_idle(200);

    // random shapes and contents
    for (int t = 0; t < 10; t++) begin
      fill_random();
      start_run($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7));
      wait_idle(400);
    end

    // reset during the third pixel, then rerun
    fill_ramp();
    log_addr.delete(); log_data.delete();
    start_run(1, 4, 4);
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    done_q.delete(); rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    chk(log_addr.size() == 2, "abort_writes_before_reset", longint'(log_addr.size()), 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    log_addr.delete(); log_data.delete();
    start_run(1, 4, 4);
    wait_idle(200);
    check_ramp_writes();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
